// File: rtl/spi_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : spi_pkg
// Purpose    : Shared definitions for the SPI memory-slave transaction
//              sequencer: state encoding and default field/counter widths.
// Contents   : SPI_WIDTH  - default bits per SPI field (address+R/W, data)
//              SPI_CNT_W  - default bit counter width (2**SPI_CNT_W > SPI_WIDTH)
//              state_e    - sequencer state encoding (4 bits; DONE is the only
//                           state using bit 3, so the low 3 bits of every other
//                           state are unique for the debug LEDs)
// Revision   : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;
  localparam int unsigned SPI_CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    GET_ADDR   = 4'd1,
    LATCH_ADDR = 4'd2,
    READ_WAIT  = 4'd3,
    READ_LOAD  = 4'd4,
    READ_SHIFT = 4'd5,
    WRITE_GET  = 4'd6,
    WRITE_MEM  = 4'd7,
    DONE       = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : spi_bit_counter
// Purpose    : SCLK edge counter for the SPI sequencer. Counts enable pulses,
//              saturates at WIDTH and is cleared by the FSM on every state
//              change.
// Ports      : clk    - system clock, rising edge
//              rst_n  - asynchronous active-low reset
//              clr_i  - synchronous clear (priority over en_i)
//              en_i   - count one relevant SCLK edge this cycle
//              tc_o   - terminal count: the edge being counted this cycle
//                       brings the count to WIDTH
// Revision   : 1.0 - initial release
// ============================================================================
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag the edge that completes the field in the same cycle it arrives, so
  // the FSM can change state on that very clock without an extra cycle of
  // latency.
  assign tc_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : spi_fsm
// Purpose    : Transaction sequencer for the SPI memory slave. Consumes the
//              conditioned chip select and SCLK edge pulses and produces the
//              strobes for the shift register, address latch, data memory and
//              MISO tri-state buffer. Frame: WIDTH-1 address bits + R/W bit,
//              then WIDTH data bits in (write) or out (read), MSB first.
// Ports      : clk          - system clock, rising edge
//              rst_n        - asynchronous active-low reset
//              cs           - chip select, active low
//              sclk_posedge - one-clk pulse per SCLK rising edge
//              sclk_negedge - one-clk pulse per SCLK falling edge
//              rw_bit       - shift register bit 0 (1 = read)
//              sr_we        - shift register parallel load strobe
//              addr_we      - address latch enable
//              dm_we        - data memory write enable
//              miso_buff_en - MISO tri-state enable
//              busy         - high whenever the sequencer is not IDLE
//              leds[3:0]    - debug state indicator
// Options    : SPI_FSM_LEDS_EN - when defined, leds = {busy, state[2:0]},
//              registered with the state; otherwise leds is tied to zero.
// Revision   : 1.0 - initial release
// ============================================================================
module spi_fsm
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       rw_bit,
  output logic       sr_we,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_buff_en,
  output logic       busy,
  output logic [3:0] leds
);

  state_e state_q;
  state_e state_d;

  logic sr_we_q,   sr_we_d;
  logic addr_we_q, addr_we_d;
  logic dm_we_q,   dm_we_d;
  logic miso_q,    miso_d;
  logic busy_q,    busy_d;

  logic cnt_en;
  logic cnt_clr;
  logic cnt_tc;

  // --------------------------------------------------------------------------
  // Bit counter: only the SCLK edge that matters in the current state is
  // counted, so a coincident opposite edge is simply ignored.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_en = 1'b0;
    case (state_q)
      GET_ADDR,
      WRITE_GET:  cnt_en = sclk_posedge;
      READ_SHIFT: cnt_en = sclk_negedge;
      default:    cnt_en = 1'b0;
    endcase
  end

  // Every state change (including an abort to IDLE) restarts the count.
  assign cnt_clr = (state_d != state_q);

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // --------------------------------------------------------------------------
  // State register; all outputs are registered alongside it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_we_q   <= 1'b0;
      addr_we_q <= 1'b0;
      dm_we_q   <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_we_q   <= sr_we_d;
      addr_we_q <= addr_we_d;
      dm_we_q   <= dm_we_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Deselect wins over any SCLK activity.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if ((state_q != IDLE) && cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (!cs)   state_d = GET_ADDR;
        GET_ADDR:   if (cnt_tc) state_d = LATCH_ADDR;
        LATCH_ADDR: state_d = rw_bit ? READ_WAIT : WRITE_GET;
        READ_WAIT:  state_d = READ_LOAD;
        READ_LOAD:  state_d = READ_SHIFT;
        READ_SHIFT: if (cnt_tc) state_d = DONE;
        WRITE_GET:  if (cnt_tc) state_d = WRITE_MEM;
        WRITE_MEM:  state_d = DONE;
        DONE:       state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, so each registered strobe lines up
  // with the state it belongs to.
  // --------------------------------------------------------------------------
  always_comb begin
    sr_we_d   = (state_d == READ_LOAD);
    addr_we_d = (state_d == LATCH_ADDR);
    dm_we_d   = (state_d == WRITE_MEM);
    busy_d    = (state_d != IDLE);
    // The master samples the last read bit on the SCLK rising edge that may
    // arrive after we reach DONE, so the MISO driver stays on in DONE after a
    // read and only drops when the transaction returns to IDLE.
    miso_d    = (state_d == READ_SHIFT) || ((state_d == DONE) && miso_q);
  end

  assign sr_we        = sr_we_q;
  assign addr_we      = addr_we_q;
  assign dm_we        = dm_we_q;
  assign miso_buff_en = miso_q;
  assign busy         = busy_q;

`ifdef SPI_FSM_LEDS_EN
  logic [3:0] leds_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= 4'b0000;
    end else begin
      leds_q <= {busy_d, state_d[2:0]};
    end
  end

  assign leds = leds_q;
`else
  assign leds = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_spi_fsm
// Purpose    : Self-checking bench for spi_fsm. Randomized SPI transactions
//              (write, read, aborts, mid-transaction reset) are described as a
//              per-cycle plan; the expected strobe events and per-cycle
//              busy/miso/leds levels are queued from the plan and a monitor
//              compares them against the DUT each cycle.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_spi_fsm;

  localparam int S_IDLE = 0, S_GET = 1, S_LATCH = 2, S_RWAIT = 3, S_RLOAD = 4;
  localparam int S_RSHIFT = 5, S_WGET = 6, S_WMEM = 7, S_DONE = 8;
  localparam int K_ADDR = 0, K_SR = 1, K_DM = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       sclk_posedge = 1'b0;
  logic       sclk_negedge = 1'b0;
  logic       rw_bit = 1'b0;
  logic       sr_we, addr_we, dm_we, miso_buff_en, busy;
  logic [3:0] leds;

  spi_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .rw_bit       (rw_bit),
    .sr_we        (sr_we),
    .addr_we      (addr_we),
    .dm_we        (dm_we),
    .miso_buff_en (miso_buff_en),
    .busy         (busy),
    .leds         (leds)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int kind; } ev_t;
  typedef struct { int cyc; int st; bit miso; } lv_t;

  ev_t evq[$];
  lv_t lvq[$];
  int  cyc     = 0;
  int  n_vec   = 0;
  int  n_err   = 0;
  bit  started = 1'b0;

  // Per-cycle plan of the transaction under construction.
  bit p_cs[$];
  bit p_pos[$];
  bit p_neg[$];
  int p_st[$];
  bit p_miso[$];
  int p_evi[$];
  int p_evk[$];

  function automatic string kname(int k);
    case (k)
      K_ADDR:  return "addr_we";
      K_SR:    return "sr_we";
      default: return "dm_we";
    endcase
  endfunction

  function automatic bit rb(int pct);
    return ($urandom_range(0, 99) < 32'(pct));
  endfunction

  function automatic logic [3:0] exp_leds(int st);
`ifdef SPI_FSM_LEDS_EN
    logic [3:0] v;
    v[3]   = (st != S_IDLE);
    v[2:0] = 3'(st);
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  // One cycle of stimulus together with the state the slave is in during it.
  task automatic win(input bit c, input bit p, input bit n, input int s, input bit m);
    p_cs.push_back(c);
    p_pos.push_back(p);
    p_neg.push_back(n);
    p_st.push_back(s);
    p_miso.push_back(m);
  endtask

  // The most recently planned cycle is where a strobe must appear.
  task automatic mark(input int k);
    p_evi.push_back(p_cs.size() - 1);
    p_evk.push_back(k);
  endtask

  // mode: 0 write, 1 read.  ab: 0 complete, 1 abort in address phase,
  // 2 abort in data phase, 3 stop after 4 write data bits (no deselect).
  task automatic build_txn(input int mode, input int ab);
    int na;
    int nd;
    bit m;
    m      = 1'b0;
    rw_bit = (mode == 1);
    repeat ($urandom_range(1, 3)) win(1'b1, rb(30), rb(30), S_IDLE, 1'b0);
    win(1'b0, rb(30), rb(30), S_IDLE, 1'b0);
    na = (ab == 1) ? int'($urandom_range(1, 7)) : 8;
    for (int i = 0; i < na; i++) begin
      repeat ($urandom_range(0, 2)) win(1'b0, 1'b0, rb(40), S_GET, 1'b0);
      win(1'b0, 1'b1, rb(25), S_GET, 1'b0);
    end
    if (ab == 1) begin
      win(1'b1, rb(50), rb(50), S_GET, 1'b0);
      return;
    end
    win(1'b0, rb(30), rb(30), S_LATCH, 1'b0);
    mark(K_ADDR);
    nd = (ab == 2) ? int'($urandom_range(1, 7)) : ((ab == 3) ? 4 : 8);
    if (mode == 0) begin
      for (int i = 0; i < nd; i++) begin
        repeat ($urandom_range(0, 2)) win(1'b0, 1'b0, rb(40), S_WGET, 1'b0);
        win(1'b0, 1'b1, rb(25), S_WGET, 1'b0);
      end
      if (ab == 3) return;
      if (ab == 2) begin
        win(1'b1, rb(50), rb(50), S_WGET, 1'b0);
        return;
      end
      win(1'b0, rb(30), rb(30), S_WMEM, 1'b0);
      mark(K_DM);
    end else begin
      win(1'b0, rb(30), rb(30), S_RWAIT, 1'b0);
      win(1'b0, rb(30), rb(30), S_RLOAD, 1'b0);
      mark(K_SR);
      for (int i = 0; i < nd; i++) begin
        repeat ($urandom_range(0, 2)) win(1'b0, rb(40), 1'b0, S_RSHIFT, 1'b1);
        win(1'b0, rb(25), 1'b1, S_RSHIFT, 1'b1);
      end
      if (ab == 2) begin
        win(1'b1, rb(50), rb(50), S_RSHIFT, 1'b1);
        return;
      end
      m = 1'b1;
    end
    // Three extra SCLK cycles in DONE must change nothing.
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2)) win(1'b0, 1'b0, rb(40), S_DONE, m);
      win(1'b0, 1'b1, rb(40), S_DONE, m);
    end
    win(1'b1, rb(50), rb(50), S_DONE, m);
  endtask

  // Queue expectations for the planned cycles, then drive them.
  task automatic play();
    int base;
    base = cyc;
    foreach (p_evi[i]) evq.push_back(ev_t'{base + p_evi[i], p_evk[i]});
    foreach (p_cs[i])  lvq.push_back(lv_t'{base + i, p_st[i], p_miso[i]});
    foreach (p_cs[i]) begin
      cs           = p_cs[i];
      sclk_posedge = p_pos[i];
      sclk_negedge = p_neg[i];
      @(posedge clk);
      #1;
      cyc++;
    end
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    p_cs.delete();
    p_pos.delete();
    p_neg.delete();
    p_st.delete();
    p_miso.delete();
    p_evi.delete();
    p_evk.delete();
  endtask

  task automatic see(input int k);
    n_vec++;
    if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].kind == k) begin
      void'(evq.pop_front());
    end else begin
      n_err++;
      if (evq.size() > 0)
        $display("FAIL strobe %s: asserted at cycle %0d, next expected %s at cycle %0d",
                 kname(k), cyc, kname(evq[0].kind), evq[0].cyc);
      else
        $display("FAIL strobe %s: asserted at cycle %0d, none expected", kname(k), cyc);
    end
  endtask

  // Monitor: compares strobes and levels mid-cycle, away from the clock edge.
  always @(negedge clk) begin : mon
    lv_t        e;
    logic [3:0] xl;
    logic       xb;
    if (started) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing %s: expected at cycle %0d, not asserted (now cycle %0d)",
                 kname(evq[0].kind), evq[0].cyc, cyc);
        void'(evq.pop_front());
      end
      if (rst_n) begin
        n_vec++;
        if ($countones({sr_we, addr_we, dm_we}) > 1) begin
          n_err++;
          $display("FAIL strobe overlap at cycle %0d: sr/addr/dm = %b%b%b, at most one high",
                   cyc, sr_we, addr_we, dm_we);
        end
        if (sr_we)   see(K_SR);
        if (addr_we) see(K_ADDR);
        if (dm_we)   see(K_DM);
        while (lvq.size() > 0 && lvq[0].cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL level check for cycle %0d never sampled", lvq[0].cyc);
          void'(lvq.pop_front());
        end
        if (lvq.size() > 0 && lvq[0].cyc == cyc) begin
          e  = lvq.pop_front();
          xb = (e.st != S_IDLE);
          xl = exp_leds(e.st);
          n_vec++;
          if (busy !== xb || miso_buff_en !== e.miso || leds !== xl) begin
            n_err++;
            $display("FAIL levels cycle %0d (state %0d): busy/miso/leds = %b/%b/%b, expected %b/%b/%b",
                     cyc, e.st, busy, miso_buff_en, leds, xb, e.miso, xl);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    n_vec++;
    if ({sr_we, addr_we, dm_we, miso_buff_en, busy, leds} !== 9'b0) begin
      n_err++;
      $display("FAIL %s: sr/addr/dm/miso/busy/leds = %b/%b/%b/%b/%b/%b, expected all 0",
               name, sr_we, addr_we, dm_we, miso_buff_en, busy, leds);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "tb_spi_fsm timeout");
  end

  initial begin : stim
    int mode;
    int ab;
    rst_n = 1'b0;
    cs    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset state");
    rst_n   = 1'b1;
    started = 1'b1;

    // Directed: plain write, plain read, address abort followed by a full write.
    build_txn(0, 0); play();
    build_txn(1, 0); play();
    build_txn(0, 1); play();
    build_txn(0, 0); play();
    build_txn(1, 2); play();
    build_txn(0, 2); play();

    // Randomized mix.
    for (int t = 0; t < 24; t++) begin
      mode = int'($urandom_range(0, 1));
      ab   = rb(30) ? int'($urandom_range(1, 2)) : 0;
      build_txn(mode, ab);
      play();
    end

    // Reset after 4 write data bits: outputs clear immediately, no write later.
    build_txn(0, 3); play();
    #1 rst_n = 1'b0;
    #1 check_all_zero("async reset mid-write");
    cs = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    repeat (4) win(1'b1, rb(30), rb(30), S_IDLE, 1'b0);
    play();

    // Reset released with cs held low: GET_ADDR on the first clock after release.
    rst_n = 1'b0;
    cs    = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    win(1'b0, 1'b0, 1'b0, S_IDLE, 1'b0);
    win(1'b1, 1'b0, 1'b0, S_GET, 1'b0);
    win(1'b1, 1'b0, 1'b0, S_IDLE, 1'b0);
    play();

    repeat (3) win(1'b1, 1'b0, 1'b0, S_IDLE, 1'b0);
    play();
    @(negedge clk);
    #1;

    n_vec++;
    if (evq.size() != 0 || lvq.size() != 0) begin
      n_err++;
      $display("FAIL leftover expectations: %0d strobe, %0d level entries, expected 0/0",
               evq.size(), lvq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
